// File: rtl/spi_reg_if.sv
// Bus between the byte-level SPI slave / hardware side and the register controller.
// The master modport is the driving side (SPI slave + hardware); slave is the controller.
interface spi_reg_if #(
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
);
  logic                 ss;
  logic [7:0]           din;
  logic                 done;
  logic [7:0]           dout;
  logic                 hw_we;
  logic [ADDR_W-1:0]    hw_addr;
  logic [7:0]           hw_wdata;
  logic [8*NREGS-1:0]   regs_flat;
  logic [NREGS-1:0]     wr_strobe;
  logic                 hw_collide;
  logic                 frame_err;

  modport master (
    output ss, din, done, hw_we, hw_addr, hw_wdata,
    input  dout, regs_flat, wr_strobe, hw_collide, frame_err
  );

  modport slave (
    input  ss, din, done, hw_we, hw_addr, hw_wdata,
    output dout, regs_flat, wr_strobe, hw_collide, frame_err
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command/register controller: decodes a command byte, then reads or writes
// the register file one byte per done, keeping the slave's next transmit byte loaded.
module spi_reg_ctrl #(
  parameter int          NREGS     = 8,
  parameter int          ADDR_W    = 3,
  parameter logic [7:0]  IDLE_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  spi_reg_if.slave   bus
);

  typedef enum logic {ST_CMD, ST_DATA} state_t;

  localparam logic [ADDR_W:0]   NREGS_X = (ADDR_W+1)'(NREGS);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NREGS-1);

  state_t                     state_reg, state_next;
  logic [ADDR_W-1:0]          addr_reg, addr_next, sel_addr, inc_addr;
  logic                       wr_reg, wr_next, inc_reg, inc_next;
  logic [7:0]                 dout_reg, dout_next, rd_val;
  logic                       ferr_reg, ferr_next;
  logic [NREGS-1:0]           strobe_reg, strobe_next;
  logic                       collide_reg, collide_next;
  logic [NREGS-1:0][7:0]      regs_reg, regs_next;
  logic                       spi_we, load_dout, addr_ok, hw_ok;

  assign addr_ok  = {1'b0, addr_reg} < NREGS_X;
  assign hw_ok    = {1'b0, bus.hw_addr} < NREGS_X;
  // Wrap at the last implemented register; out-of-range addresses roll over naturally.
  assign inc_addr = (addr_reg == LAST) ? '0 : addr_reg + ADDR_W'(1);

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wr_next    = wr_reg;
    inc_next   = inc_reg;
    ferr_next  = ferr_reg;
    spi_we     = 1'b0;
    load_dout  = 1'b0;
    sel_addr   = addr_reg;
    if (bus.ss) begin
      state_next = ST_CMD;
    end else if (bus.done) begin
      case (state_reg)
        ST_CMD: begin
          wr_next    = bus.din[7];
          inc_next   = bus.din[6];
          addr_next  = bus.din[ADDR_W-1:0];
          ferr_next  = 1'b0;
          state_next = ST_DATA;
          load_dout  = 1'b1;
          sel_addr   = bus.din[ADDR_W-1:0];
        end
        default: begin
          if (!addr_ok)
            ferr_next = 1'b1;
          else if (wr_reg)
            spi_we = 1'b1;
          if (inc_reg)
            addr_next = inc_addr;
          load_dout = 1'b1;
          sel_addr  = inc_reg ? inc_addr : addr_reg;
        end
      endcase
    end
  end

  assign collide_next = bus.hw_we && hw_ok && spi_we && (bus.hw_addr == addr_reg);

  // SPI write has priority over a hardware write to the same register.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      logic spi_hit, hw_hit;
      assign spi_hit          = spi_we && (addr_reg == ADDR_W'(gi));
      assign hw_hit           = bus.hw_we && (bus.hw_addr == ADDR_W'(gi));
      assign regs_next[gi]    = spi_hit ? bus.din : (hw_hit ? bus.hw_wdata : regs_reg[gi]);
      assign strobe_next[gi]  = spi_hit;
    end
  endgenerate

  // Read from the post-write view so the transmit byte sees this cycle's writes.
  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NREGS; i++) begin
      if (sel_addr == ADDR_W'(i))
        rd_val = regs_next[i];
    end
  end

  always_comb begin
    dout_next = dout_reg;
    if (bus.ss)
      dout_next = IDLE_BYTE;
    else if (load_dout)
      dout_next = rd_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_CMD;
      addr_reg    <= '0;
      wr_reg      <= 1'b0;
      inc_reg     <= 1'b0;
      dout_reg    <= IDLE_BYTE;
      ferr_reg    <= 1'b0;
      strobe_reg  <= '0;
      collide_reg <= 1'b0;
      regs_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      wr_reg      <= wr_next;
      inc_reg     <= inc_next;
      dout_reg    <= dout_next;
      ferr_reg    <= ferr_next;
      strobe_reg  <= strobe_next;
      collide_reg <= collide_next;
      regs_reg    <= regs_next;
    end
  end

  assign bus.dout       = dout_reg;
  assign bus.regs_flat  = regs_reg;
  assign bus.wr_strobe  = strobe_reg;
  assign bus.hw_collide = collide_reg;
  assign bus.frame_err  = ferr_reg;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Drives an 8-register and a 4-register controller with identical stimulus and
// checks both against a transaction-level model plus a table of known answers.
module tb_spi_reg_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       ss, done, hw_we;
  logic [7:0] din, hw_wdata;
  logic [2:0] hw_addr;

  spi_reg_if #(.NREGS(8), .ADDR_W(3)) if8 ();
  spi_reg_if #(.NREGS(4), .ADDR_W(3)) if4 ();

  assign if8.ss = ss;       assign if4.ss = ss;
  assign if8.din = din;     assign if4.din = din;
  assign if8.done = done;   assign if4.done = done;
  assign if8.hw_we = hw_we; assign if4.hw_we = hw_we;
  assign if8.hw_addr = hw_addr;   assign if4.hw_addr = hw_addr;
  assign if8.hw_wdata = hw_wdata; assign if4.hw_wdata = hw_wdata;

  spi_reg_ctrl #(.NREGS(8), .ADDR_W(3), .IDLE_BYTE(8'hA5)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));
  spi_reg_ctrl #(.NREGS(4), .ADDR_W(3), .IDLE_BYTE(8'hA5)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, index 0 = 8 registers, 1 = 4 registers.
  int m_regs [2][8];
  int m_addr [2];
  bit m_wr [2], m_inc [2], m_ferr [2], m_data [2], m_col [2];
  int m_dout [2];
  int m_strobe [2];

  function automatic int nr(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_regs[k][i] = 0;
      m_addr[k] = 0; m_wr[k] = 0; m_inc[k] = 0; m_ferr[k] = 0; m_data[k] = 0;
      m_dout[k] = 'hA5; m_strobe[k] = 0; m_col[k] = 0;
    end
  endtask

  // One clock of the model, computed from the inputs about to be sampled.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int n = nr(k);
      bit spi_hit = 0;
      m_strobe[k] = 0;
      m_col[k] = 0;
      if (!ss && done && m_data[k]) begin
        if (m_addr[k] >= n) m_ferr[k] = 1;
        else if (m_wr[k]) begin
          spi_hit = 1;
          m_regs[k][m_addr[k]] = int'(din);
          m_strobe[k] = 1 << m_addr[k];
        end
      end
      if (hw_we && int'(hw_addr) < n) begin
        if (spi_hit && int'(hw_addr) == m_addr[k]) m_col[k] = 1;
        else m_regs[k][hw_addr] = int'(hw_wdata);
      end
      if (ss) begin
        m_data[k] = 0;
        m_dout[k] = 'hA5;
      end else if (done) begin
        if (!m_data[k]) begin
          m_wr[k] = din[7]; m_inc[k] = din[6]; m_addr[k] = int'(din) % 8;
          m_ferr[k] = 0; m_data[k] = 1;
        end else if (m_inc[k]) begin
          m_addr[k] = (m_addr[k] == n - 1) ? 0 : (m_addr[k] + 1) % 8;
        end
        m_dout[k] = (m_addr[k] < n) ? m_regs[k][m_addr[k]] : 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      logic [63:0] ef = '0;
      logic [63:0] af;
      int n = nr(k);
      for (int i = 0; i < n; i++) ef[8*i +: 8] = m_regs[k][i][7:0];
      af = (k == 0) ? 64'(if8.regs_flat) : 64'(if4.regs_flat);
      chk($sformatf("%s dout%0d", tag, n), (k == 0) ? 64'(if8.dout) : 64'(if4.dout), 64'(m_dout[k]));
      chk($sformatf("%s regs%0d", tag, n), af, ef);
      chk($sformatf("%s ferr%0d", tag, n), (k == 0) ? 64'(if8.frame_err) : 64'(if4.frame_err), 64'(m_ferr[k]));
      chk($sformatf("%s strobe%0d", tag, n), (k == 0) ? 64'(if8.wr_strobe) : 64'(if4.wr_strobe), 64'(m_strobe[k]));
      chk($sformatf("%s col%0d", tag, n), (k == 0) ? 64'(if8.hw_collide) : 64'(if4.hw_collide), 64'(m_col[k]));
    end
  endtask

  task automatic step(input bit s, input logic [7:0] d, input bit dn,
                      input bit hw, input logic [2:0] ha, input logic [7:0] hd, input string tag);
    ss = s; din = d; done = dn; hw_we = hw; hw_addr = ha; hw_wdata = hd;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit         ss;
    logic [7:0] din;
    bit         done;
    bit         hw_we;
    logic [2:0] hw_addr;
    logic [7:0] hw_wdata;
    logic [7:0] exp_dout8;
    bit         exp_ferr4;
    bit         exp_col8;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit s, logic [7:0] d, bit dn, bit hw, logic [2:0] ha,
                              logic [7:0] hd, logic [7:0] ed, bit ef, bit ec);
    vec_t v;
    v.ss = s; v.din = d; v.done = dn; v.hw_we = hw; v.hw_addr = ha; v.hw_wdata = hd;
    v.exp_dout8 = ed; v.exp_ferr4 = ef; v.exp_col8 = ec;
    return v;
  endfunction

  initial begin
    // Write frame, INC from addr 2
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 8'hA5, 0, 0));
    tbl.push_back(mk(0, 8'hC2, 1, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h11, 1, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h22, 1, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h33, 1, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 8'hA5, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 8'h00, 0, 1, 3'(i), 8'(8'h70 + i), 8'hA5, 0, 0));
    // Read with wrap from addr 7
    tbl.push_back(mk(0, 8'h47, 1, 0, 0, 8'h00, 8'h77, 0, 0));
    tbl.push_back(mk(0, 8'hFF, 1, 0, 0, 8'h00, 8'h70, 1, 0));
    tbl.push_back(mk(0, 8'hFF, 1, 0, 0, 8'h00, 8'h71, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 8'h71, 1, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 8'hA5, 1, 0));
    // Non-INC write then bypass read-back
    tbl.push_back(mk(0, 8'h85, 1, 0, 0, 8'h00, 8'h75, 0, 0));
    tbl.push_back(mk(0, 8'h5A, 1, 0, 0, 8'h00, 8'h5A, 1, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 8'hA5, 1, 0));
    tbl.push_back(mk(0, 8'h86, 1, 0, 0, 8'h00, 8'h76, 0, 0));
    tbl.push_back(mk(0, 8'h99, 1, 0, 0, 8'h00, 8'h99, 1, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 8'hA5, 1, 0));
    // Collision and parallel hardware write
    tbl.push_back(mk(0, 8'h83, 1, 0, 0, 8'h00, 8'h73, 0, 0));
    tbl.push_back(mk(0, 8'h12, 1, 1, 3, 8'hEE, 8'h12, 0, 1));
    tbl.push_back(mk(0, 8'h34, 1, 1, 1, 8'h44, 8'h34, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 8'hA5, 0, 0));
    // Abort after command; next frame decodes a fresh command
    tbl.push_back(mk(0, 8'h81, 1, 0, 0, 8'h00, 8'h44, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 8'hA5, 0, 0));
    tbl.push_back(mk(0, 8'h02, 1, 0, 0, 8'h00, 8'h72, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 8'h72, 0, 0));
    // done during ss=1 is ignored
    tbl.push_back(mk(1, 8'h85, 1, 0, 0, 8'h00, 8'hA5, 0, 0));
    tbl.push_back(mk(0, 8'h02, 1, 0, 0, 8'h00, 8'h72, 0, 0));
    // Hardware write onto the register being loaded into dout
    tbl.push_back(mk(0, 8'h00, 1, 1, 2, 8'hBB, 8'hBB, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 8'hA5, 0, 0));

    rst = 1'b1; ss = 1'b1; din = '0; done = 1'b0; hw_we = 1'b0; hw_addr = '0; hw_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("reset");
    $display("[TB] reset released dout8=%02h dout4=%02h", if8.dout, if4.dout);

    foreach (tbl[i]) begin
      step(tbl[i].ss, tbl[i].din, tbl[i].done, tbl[i].hw_we, tbl[i].hw_addr, tbl[i].hw_wdata,
           $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_dout8", i), 64'(if8.dout), 64'(tbl[i].exp_dout8));
      chk($sformatf("vec%0d tbl_ferr4", i), 64'(if4.frame_err), 64'(tbl[i].exp_ferr4));
      chk($sformatf("vec%0d tbl_col8", i), 64'(if8.hw_collide), 64'(tbl[i].exp_col8));
      $display("[TB] vec %0d ss=%0b done=%0b din=%02h hw=%0b dout8=%02h ferr4=%0b",
               i, tbl[i].ss, tbl[i].done, tbl[i].din, tbl[i].hw_we, if8.dout, if4.frame_err);
    end

    // Asynchronous reset mid-frame
    step(0, 8'hC0, 1, 0, 0, 8'h00, "pre_rst");
    step(0, 8'h3C, 1, 0, 0, 8'h00, "pre_rst2");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst dout8", 64'(if8.dout), 64'hA5);
    chk("async_rst regs8", 64'(if8.regs_flat), 64'h0);
    chk("async_rst ferr4", 64'(if4.frame_err), 64'h0);
    check_all("async_rst");
    $display("[TB] async reset mid-frame dout8=%02h", if8.dout);
    ss = 1'b1; done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Randomised traffic against the model
    for (int c = 0; c < 1500; c++) begin
      bit s = ($urandom_range(0, 15) == 0);
      if (s && !ss) $display("[TB] random frame ended at cycle %0d dout8=%02h", c, if8.dout);
      step(s, 8'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
           3'($urandom), 8'($urandom), $sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command/register controller for the hardware side of the byte-level SPI slave: consumes received bytes (din/done), decodes a command byte, executes register reads/writes, and keeps the slave's transmit byte (dout) loaded.
- Gives an SPI master a small register file (control/config registers) plus a hardware-side write port for status values.
- Sits between the SPI slave and the rest of the design; it owns the register file.

Parameters:
- NREGS, 8, number of 8-bit registers (1..2**ADDR_W)
- ADDR_W, 3, width of the register address field in the command byte (1..6)
- IDLE_BYTE, 8'hA5, byte presented on dout while the command byte is shifting

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  asynchronous, active-high reset
- ss  input  1  SPI slave select (high = deselected), already synchronous to clk; frame boundary
- din  input  8  byte received from SPI slave
- done  input  1  one-cycle pulse, din valid this cycle
- dout  output  8  byte the SPI slave shifts out next (registered)
- hw_we  input  1  hardware write strobe
- hw_addr  input  ADDR_W  hardware write address
- hw_wdata  input  8  hardware write data
- regs_flat  output  8*NREGS  register contents, reg[i] at bits [8*i+7:8*i]
- wr_strobe  output  NREGS  one-cycle pulse per register written over SPI
- hw_collide  output  1  one-cycle pulse, hardware write dropped
- frame_err  output  1  sticky; set on out-of-range address; cleared by rst or by a new command byte

Behaviour:
- Reset (async, rst=1):
  - all registers 8'h00, state=CMD, dout=IDLE_BYTE
  - wr_strobe=0, hw_collide=0, frame_err=0, addr=0, cmd flags=0
- Command byte format:
  - bit7 = WR (1 write, 0 read)
  - bit6 = INC (auto-increment)
  - bits[ADDR_W-1:0] = start address
  - remaining bits ignored
- State CMD:
  - on done: latch WR, INC, addr=din[ADDR_W-1:0]; clear frame_err; go to DATA
  - next cycle: dout = reg[addr] (0x00 if addr >= NREGS)
  - latency from done to dout update is exactly 1 clk
- State DATA, on each done:
  - If WR and addr < NREGS: reg[addr] <= din; wr_strobe[addr] pulses the following cycle for 1 clk.
  - If WR and addr >= NREGS: write dropped, frame_err <= 1.
  - Read: din ignored; reads of addr >= NREGS set frame_err and return 0x00.
  - If INC: addr <= (addr == NREGS-1) ? 0 : addr+1, so the address wraps at NREGS-1. Out-of-range start addresses still increment modulo 2**ADDR_W.
  - dout <= value of reg[next_addr] after this cycle's write (write-through bypass), so a non-INC write then read-back returns the new value.
  - Remain in DATA until ss.
- ss=1 (at any time, including mid-frame):
  - next clk: state=CMD, dout=IDLE_BYTE, addr unchanged but irrelevant
  - registers retain values; an in-flight partial byte is never seen (no done)
  - done while ss=1 is ignored
- Hardware write port:
  - hw_we=1: reg[hw_addr] <= hw_wdata next clk; hw_addr >= NREGS ignored silently
  - If an SPI write to the same address occurs in the same cycle, SPI wins, the hw write is dropped, and hw_collide pulses 1 clk.
  - Different addresses: both apply.
  - hw writes never pulse wr_strobe.
  - If a hw write hits the register selected for the next dout in the same cycle, dout takes the hw value.
- done in consecutive cycles must be handled (one byte per done, no drops).
- No combinational path from din/done to dout.

Test Plan:
- Reset release -> dout=8'hA5, regs_flat all 0, frame_err=0; asserting rst mid-frame returns the same values immediately (async).
- Frame ss=0: bytes 8'hC2, 8'h11, 8'h22, 8'h33 (WR, INC, addr 2) -> reg2=11, reg3=22, reg4=33; wr_strobe pulses bits 2, 3, 4 in order; dout after cmd = old reg2 = 00.
- NREGS=8, frame 8'h47 (read, INC, addr 7) with regs preloaded 0x70..0x77 -> dout sequence 0x77, 0x70, 0x71 (wrap); frame_err stays 0.
- Write 8'h85 then 8'h5A (no INC) -> next dout=5A (bypass), reg5=5A; with NREGS=4, cmd 8'h86 plus byte -> frame_err=1, no reg change; next cmd byte clears frame_err.
- hw_we addr3=0xEE in the same cycle as an SPI write addr3=0x12 -> reg3=12, hw_collide=1 for 1 clk; hw write addr1 in the same cycle -> both applied, no collide.
- ss raised after the command byte only -> state CMD, dout=A5, no reg change; next frame decodes its first byte as a command.
